edge_pulse_gen: RTL

EDGE_PULSE_GEN -- requirements
Module: edge_pulse_gen

---
 rtl/edge_pulse_gen_pkg.sv | 45 ++++
 rtl/edge_pulse_gen_sync.sv | 25 ++
 rtl/edge_pulse_gen.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/edge_pulse_gen_pkg.sv
// Shared definitions for the edge pulse generator and neighbouring blocks:
// parameter defaults, legal parameter ranges and the edge classification
// helper used by the pulse logic.
package edge_pulse_gen_pkg;

  // Parameter defaults.
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_DEBOUNCE_CYC = 4;
  localparam int DEF_CNT_W        = 8;

  // Legal parameter ranges.
  localparam int SYNC_STAGES_MIN  = 2;
  localparam int SYNC_STAGES_MAX  = 4;
  localparam int DEBOUNCE_CYC_MIN = 1;
  localparam int DEBOUNCE_CYC_MAX = 255;
  localparam int CNT_W_MIN        = 1;

  // Debounce counter width, large enough for DEBOUNCE_CYC_MAX - 1.
  localparam int DEB_W = 8;

  // Kind of level transition accepted by the debouncer in a given cycle.
  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_POS  = 2'd1,
    EDGE_NEG  = 2'd2
  } edge_kind_e;

  // Classify a debouncer acceptance: when a new level is accepted, the new
  // level value tells which direction the transition went.
  function automatic edge_kind_e classify_edge(input logic accept,
                                               input logic new_level);
    edge_kind_e kind;
    if (accept) begin
      if (new_level) begin
        kind = EDGE_POS;
      end else begin
        kind = EDGE_NEG;
      end
    end else begin
      kind = EDGE_NONE;
    end
    return kind;
  endfunction

endpackage : edge_pulse_gen_pkg

// File: rtl/edge_pulse_gen_sync.sv
// Multi-flop synchronizer for a single asynchronous level. The only place
// the raw input is sampled; q is the output of the last stage.
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the raw level through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule : edge_sync

// File: rtl/edge_pulse_gen.sv
// Edge pulse generator: synchronizes an asynchronous level, debounces it,
// emits registered single-cycle strobes on accepted rising/falling
// transitions, and keeps saturating edge counters plus sticky edge flags.
//
// The debouncer always tracks the input, independent of en, so a
// transition absorbed while disabled never produces a late strobe.
// Counters and sticky flags update on the same edge that loads the strobe,
// which lets clr win cleanly over a coincident transition while the strobe
// itself is still delivered.
module edge_pulse_gen
  import edge_pulse_gen_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             en,
  input  logic             clr,
  output logic             level,
  output logic             pos_pulse,
  output logic             neg_pulse,
  output logic             any_pulse,
  output logic [CNT_W-1:0] pos_cnt,
  output logic [CNT_W-1:0] neg_cnt,
  output logic             pos_seen,
  output logic             neg_seen
);

  // Reject illegal parameterisations at elaboration time.
  if ((SYNC_STAGES < SYNC_STAGES_MIN) || (SYNC_STAGES > SYNC_STAGES_MAX)) begin : g_bad_sync
    $error("edge_pulse_gen: SYNC_STAGES out of range");
  end
  if ((DEBOUNCE_CYC < DEBOUNCE_CYC_MIN) || (DEBOUNCE_CYC > DEBOUNCE_CYC_MAX)) begin : g_bad_deb
    $error("edge_pulse_gen: DEBOUNCE_CYC out of range");
  end
  if (CNT_W < CNT_W_MIN) begin : g_bad_cnt
    $error("edge_pulse_gen: CNT_W out of range");
  end

  // Last debounce count before a mismatching level is accepted.
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Synchronized input.
  logic             din_sync_s;

  // Debouncer state and next-state.
  logic [DEB_W-1:0] deb_cnt_r;
  logic [DEB_W-1:0] deb_cnt_nxt_s;
  logic             level_r;
  logic             level_nxt_s;
  logic             accept_s;

  // Edge decode.
  edge_kind_e       edge_kind_s;
  logic             pos_set_s;
  logic             neg_set_s;

  // Registered outputs.
  logic             pos_pulse_r;
  logic             neg_pulse_r;
  logic             any_pulse_r;
  logic [CNT_W-1:0] pos_cnt_r;
  logic [CNT_W-1:0] neg_cnt_r;
  logic             pos_seen_r;
  logic             neg_seen_r;

  edge_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (din),
    .q     (din_sync_s)
  );

  // Debounce next-state: count consecutive mismatches, accept on the last.
  always_comb begin
    deb_cnt_nxt_s = {DEB_W{1'b0}};
    level_nxt_s   = level_r;
    accept_s      = 1'b0;
    if (din_sync_s != level_r) begin
      if (deb_cnt_r == DEB_LAST) begin
        accept_s      = 1'b1;
        level_nxt_s   = din_sync_s;
        deb_cnt_nxt_s = {DEB_W{1'b0}};
      end else begin
        deb_cnt_nxt_s = deb_cnt_r + DEB_ONE;
      end
    end else begin
      deb_cnt_nxt_s = {DEB_W{1'b0}};
    end
  end

  // Decode the accepted transition into enabled rising/falling set strobes.
  always_comb begin
    pos_set_s   = 1'b0;
    neg_set_s   = 1'b0;
    edge_kind_s = classify_edge(accept_s, din_sync_s);
    case (edge_kind_s)
      EDGE_POS: pos_set_s = en;
      EDGE_NEG: neg_set_s = en;
      EDGE_NONE: begin
        pos_set_s = 1'b0;
        neg_set_s = 1'b0;
      end
      default: begin
        pos_set_s = 1'b0;
        neg_set_s = 1'b0;
      end
    endcase
  end

  // Debouncer state register; tracks the input regardless of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_r <= {DEB_W{1'b0}};
      level_r   <= 1'b0;
    end else begin
      deb_cnt_r <= deb_cnt_nxt_s;
      level_r   <= level_nxt_s;
    end
  end

  // Single-cycle edge strobes; clr does not suppress them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_pulse_r <= 1'b0;
      neg_pulse_r <= 1'b0;
      any_pulse_r <= 1'b0;
    end else begin
      pos_pulse_r <= pos_set_s;
      neg_pulse_r <= neg_set_s;
      any_pulse_r <= pos_set_s | neg_set_s;
    end
  end

  // Rising-edge counter (saturating) and sticky flag; clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_cnt_r  <= {CNT_W{1'b0}};
      pos_seen_r <= 1'b0;
    end else if (clr) begin
      pos_cnt_r  <= {CNT_W{1'b0}};
      pos_seen_r <= 1'b0;
    end else if (pos_set_s) begin
      if (pos_cnt_r != CNT_MAX) begin
        pos_cnt_r <= pos_cnt_r + CNT_ONE;
      end else begin
        pos_cnt_r <= pos_cnt_r;
      end
      pos_seen_r <= 1'b1;
    end else begin
      pos_cnt_r  <= pos_cnt_r;
      pos_seen_r <= pos_seen_r;
    end
  end

  // Falling-edge counter (saturating) and sticky flag; clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_cnt_r  <= {CNT_W{1'b0}};
      neg_seen_r <= 1'b0;
    end else if (clr) begin
      neg_cnt_r  <= {CNT_W{1'b0}};
      neg_seen_r <= 1'b0;
    end else if (neg_set_s) begin
      if (neg_cnt_r != CNT_MAX) begin
        neg_cnt_r <= neg_cnt_r + CNT_ONE;
      end else begin
        neg_cnt_r <= neg_cnt_r;
      end
      neg_seen_r <= 1'b1;
    end else begin
      neg_cnt_r  <= neg_cnt_r;
      neg_seen_r <= neg_seen_r;
    end
  end

  assign level     = level_r;
  assign pos_pulse = pos_pulse_r;
  assign neg_pulse = neg_pulse_r;
  assign any_pulse = any_pulse_r;
  assign pos_cnt   = pos_cnt_r;
  assign neg_cnt   = neg_cnt_r;
  assign pos_seen  = pos_seen_r;
  assign neg_seen  = neg_seen_r;

endmodule : edge_pulse_gen
